// File: rtl/dsp_pkg.sv
// Shared DSP definitions: loader FSM states, default command byte, bytes-per-word helper.
package dsp_pkg;

    // Command byte that opens a parameter write packet.
    localparam logic [7:0] CMD_WRITE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        CNT_HI,
        CNT_LO,
        DATA
    } loader_state_t;

    // Number of stream bytes carrying one parameter word: ceil(width / 8).
    function automatic int unsigned bpw(input int unsigned width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte-to-word assembler for the parameter loader.
// Only the low WIDTH bits of the BPW-byte word are kept; the bits shifted out
// of the top are exactly the ones the packet format says to ignore.
module word_assembler
    import dsp_pkg::*;
#(
    parameter int unsigned WIDTH = 36
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic [7:0]       data,
    output logic [WIDTH-1:0] word,
    output logic             word_done
);

    localparam int unsigned BYTES = bpw(WIDTH);
    localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [WIDTH-1:0] shreg;
    logic [IDX_W-1:0] byte_idx;

    // Word including the byte presented this cycle, so the top level can issue
    // the write on the same edge that accepts the final byte.
    assign word      = WIDTH'({shreg, data});
    assign word_done = shift_en && (byte_idx == IDX_W'(BYTES - 1));

    // Shift register and byte counter; clear discards any partial word.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shreg    <= '0;
            byte_idx <= '0;
        end else if (shift_en) begin
            shreg    <= word;
            byte_idx <= word_done ? '0 : byte_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/param_loader.sv
// Host-side writer for the DSP parameter memory: parses write packets from a
// byte stream and issues one param_mem write per assembled word.
module param_loader
    import dsp_pkg::*;
#(
    parameter int unsigned PARAM_WIDTH      = 36,
    parameter int unsigned PARAM_ADDR_WIDTH = 10,
    parameter int unsigned TIMEOUT_CYCLES   = 65535,
    parameter logic [7:0]  CMD_WRITE        = CMD_WRITE_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  in_data,
    output logic                        param_wr_en,
    output logic [PARAM_ADDR_WIDTH-1:0] param_wr_addr,
    output logic [PARAM_WIDTH-1:0]      param_wr_data,
    output logic                        busy,
    output logic                        done,
    output logic                        err_cmd,
    output logic                        err_timeout
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    if (PARAM_WIDTH == 0 || PARAM_WIDTH > 40) begin : g_width_check
        $error("param_loader: PARAM_WIDTH must be in 1..40");
    end

    loader_state_t               state;
    logic [7:0]                  addr_hi_byte;
    logic [7:0]                  cnt_hi_byte;
    logic [PARAM_ADDR_WIDTH-1:0] addr;
    logic [15:0]                 words_left;
    logic [TO_W-1:0]             idle_cnt;

    logic                        accept;
    logic                        timeout_hit;
    logic                        asm_clear;
    logic                        asm_shift;
    logic [PARAM_WIDTH-1:0]      asm_word;
    logic                        asm_done;
    logic [15:0]                 count_full;

    // The loader never stalls the host; ready only drops while in reset.
    assign in_ready    = !reset;
    assign accept      = in_valid && in_ready;
    assign busy        = (state != IDLE);
    assign timeout_hit = (state != IDLE) && (idle_cnt == TO_W'(TIMEOUT_CYCLES));
    assign count_full  = {cnt_hi_byte, in_data};

    // A byte arriving in the timeout cycle is ignored, so it must not shift in.
    assign asm_clear = (state != DATA);
    assign asm_shift = accept && (state == DATA) && !timeout_hit;

    word_assembler #(
        .WIDTH (PARAM_WIDTH)
    ) u_word_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .shift_en  (asm_shift),
        .data      (in_data),
        .word      (asm_word),
        .word_done (asm_done)
    );

    // Packet FSM with address/count tracking, idle timeout and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            addr_hi_byte  <= '0;
            cnt_hi_byte   <= '0;
            addr          <= '0;
            words_left    <= '0;
            idle_cnt      <= '0;
            param_wr_en   <= 1'b0;
            param_wr_addr <= '0;
            param_wr_data <= '0;
            done          <= 1'b0;
            err_cmd       <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            param_wr_en <= 1'b0;
            done        <= 1'b0;
            err_cmd     <= 1'b0;
            err_timeout <= 1'b0;

            if (state == IDLE || accept) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TO_W'(1);
            end

            if (timeout_hit) begin
                // Completed writes stand; the partial word is dropped by asm_clear.
                state       <= IDLE;
                idle_cnt    <= '0;
                err_timeout <= 1'b1;
            end else if (accept) begin
                unique case (state)
                    IDLE: begin
                        if (in_data == CMD_WRITE) begin
                            state <= ADDR_HI;
                        end else begin
                            err_cmd <= 1'b1;
                        end
                    end
                    ADDR_HI: begin
                        addr_hi_byte <= in_data;
                        state        <= ADDR_LO;
                    end
                    ADDR_LO: begin
                        addr  <= PARAM_ADDR_WIDTH'({addr_hi_byte, in_data});
                        state <= CNT_HI;
                    end
                    CNT_HI: begin
                        cnt_hi_byte <= in_data;
                        state       <= CNT_LO;
                    end
                    CNT_LO: begin
                        words_left <= count_full;
                        if (count_full == 16'd0) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        if (asm_done) begin
                            param_wr_en   <= 1'b1;
                            param_wr_addr <= addr;
                            param_wr_data <= asm_word;
                            addr          <= addr + PARAM_ADDR_WIDTH'(1);
                            words_left    <= words_left - 16'd1;
                            if (words_left == 16'd1) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_param_loader.sv
// Self-checking bench for param_loader: directed scenarios plus randomized packets
// checked against a packet-level reference model.
module tb_param_loader;

    localparam int unsigned PW = 36;
    localparam int unsigned AW = 10;
    localparam int unsigned TO = 16;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data  = 8'h00;
    logic          in_ready;
    logic          param_wr_en;
    logic [AW-1:0] param_wr_addr;
    logic [PW-1:0] param_wr_data;
    logic          busy;
    logic          done;
    logic          err_cmd;
    logic          err_timeout;

    param_loader #(
        .PARAM_WIDTH      (PW),
        .PARAM_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES   (TO),
        .CMD_WRITE        (8'hA5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .param_wr_en   (param_wr_en),
        .param_wr_addr (param_wr_addr),
        .param_wr_data (param_wr_data),
        .busy          (busy),
        .done          (done),
        .err_cmd       (err_cmd),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Rising-edge count; stable when sampled at the falling edge.
    int edge_cnt   = 0;
    int last_stamp = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Observed activity, sampled mid-cycle.
    int            mon_addr[$];
    logic [PW-1:0] mon_data[$];
    int            mon_stamp[$];
    bit            mon_done_w[$];
    int            done_stamp[$];
    int            errc_stamp[$];
    int            errt_stamp[$];

    always @(negedge clk) begin
        if (param_wr_en) begin
            mon_addr.push_back(int'(param_wr_addr));
            mon_data.push_back(param_wr_data);
            mon_stamp.push_back(edge_cnt);
            mon_done_w.push_back(done);
        end
        if (done)        done_stamp.push_back(edge_cnt);
        if (err_cmd)     errc_stamp.push_back(edge_cnt);
        if (err_timeout) errt_stamp.push_back(edge_cnt);
    end

    // Reference model: a packet (start address, words) maps to a list of writes.
    logic [39:0]   tx_words[$];
    int            exp_addr[$];
    logic [PW-1:0] exp_data[$];

    task automatic model_packet(input logic [15:0] a, input int n);
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back((int'(a) + i) % (1 << AW));
            exp_data.push_back(tx_words[i][PW-1:0]);
        end
    endtask

    task automatic clear_mon();
        mon_addr.delete();
        mon_data.delete();
        mon_stamp.delete();
        mon_done_w.delete();
        done_stamp.delete();
        errc_stamp.delete();
        errt_stamp.delete();
    endtask

    task automatic drive_byte(input logic [7:0] b);
        @(negedge clk);
        in_valid   = 1'b1;
        in_data    = b;
        last_stamp = edge_cnt;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'h00;
        end
    endtask

    task automatic gap(input int gap_max);
        if (gap_max > 0) idle($urandom_range(0, gap_max));
    endtask

    // Sends a full write packet using tx_words as payload (BPW = 5 bytes each).
    task automatic send_packet(input logic [15:0] a, input logic [15:0] n, input int gap_max);
        drive_byte(8'hA5);  gap(gap_max);
        drive_byte(a[15:8]); gap(gap_max);
        drive_byte(a[7:0]);  gap(gap_max);
        drive_byte(n[15:8]); gap(gap_max);
        drive_byte(n[7:0]);
        for (int w = 0; w < int'(n); w++) begin
            for (int j = 4; j >= 0; j--) begin
                gap(gap_max);
                drive_byte(tx_words[w][8*j +: 8]);
            end
        end
    endtask

    task automatic rand_words(input int n);
        logic [63:0] r;
        tx_words.delete();
        for (int i = 0; i < n; i++) begin
            r = {$urandom(), $urandom()};
            tx_words.push_back(r[39:0]);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        end
        checks++;
        if ({param_wr_en, param_wr_addr, param_wr_data} !== '0) begin
            failures++;
            $display("FAIL reset_wr_port got=%b/%h/%h exp=0/0/0",
                     param_wr_en, param_wr_addr, param_wr_data);
        end
        checks++;
        if ({busy, done, err_cmd, err_timeout} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_status got=%b exp=0000", {busy, done, err_cmd, err_timeout});
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_in_ready got=%b exp=1", in_ready);
        end
        idle(2);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL release_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_single_word();
        clear_mon();
        tx_words.delete();
        tx_words.push_back(40'h0F12345678);
        send_packet(16'h0010, 16'd1, 0);
        idle(4);
        #1;
        checks++;
        if (mon_addr.size() != 1) begin
            failures++;
            $display("FAIL single_count got=%0d exp=1", mon_addr.size());
        end else begin
            checks++;
            if (mon_addr[0] != 'h010 || mon_data[0] !== 36'hF12345678) begin
                failures++;
                $display("FAIL single_write got=%h/%h exp=010/f12345678",
                         mon_addr[0], mon_data[0]);
            end
            checks++;
            if (mon_stamp[0] != last_stamp + 1 || mon_done_w[0] !== 1'b1) begin
                failures++;
                $display("FAIL single_timing got=%0d/done=%b exp=%0d/done=1",
                         mon_stamp[0], mon_done_w[0], last_stamp + 1);
            end
        end
        checks++;
        if (done_stamp.size() != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_done got=%0d/busy=%b exp=1/busy=0", done_stamp.size(), busy);
        end
    endtask

    task automatic test_burst_wrap();
        clear_mon();
        rand_words(3);
        send_packet(16'h03FE, 16'd3, 0);
        idle(4);
        #1;
        model_packet(16'h03FE, 3);
        checks++;
        if (mon_addr.size() != 3) begin
            failures++;
            $display("FAIL burst_count got=%0d exp=3", mon_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (mon_addr[i] != exp_addr[i] || mon_data[i] !== exp_data[i] ||
                    mon_stamp[i] != last_stamp + 1 - 5 * (2 - i)) begin
                    failures++;
                    $display("FAIL burst_write%0d got=%h/%h@%0d exp=%h/%h@%0d", i, mon_addr[i],
                             mon_data[i], mon_stamp[i], exp_addr[i], exp_data[i],
                             last_stamp + 1 - 5 * (2 - i));
                end
            end
            checks++;
            if (done_stamp.size() != 1 || mon_done_w[2] !== 1'b1) begin
                failures++;
                $display("FAIL burst_done got=%0d/last=%b exp=1/last=1",
                         done_stamp.size(), mon_done_w[2]);
            end
        end
    endtask

    task automatic test_bad_cmd();
        int bad_stamp;
        clear_mon();
        drive_byte(8'h5A);
        bad_stamp = last_stamp;
        idle(2);
        #1;
        checks++;
        if (errc_stamp.size() != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL badcmd_pulse got=%0d/busy=%b exp=1/busy=0", errc_stamp.size(), busy);
        end else begin
            checks++;
            if (errc_stamp[0] != bad_stamp + 1) begin
                failures++;
                $display("FAIL badcmd_timing got=%0d exp=%0d", errc_stamp[0], bad_stamp + 1);
            end
        end
        rand_words(2);
        send_packet(16'h1234, 16'd2, 2);
        idle(4);
        #1;
        model_packet(16'h1234, 2);
        checks++;
        if (mon_addr.size() != 2 || done_stamp.size() != 1 || errc_stamp.size() != 1) begin
            failures++;
            $display("FAIL badcmd_follow got=w%0d/d%0d/e%0d exp=w2/d1/e1",
                     mon_addr.size(), done_stamp.size(), errc_stamp.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (mon_addr[i] != exp_addr[i] || mon_data[i] !== exp_data[i]) begin
                    failures++;
                    $display("FAIL badcmd_write%0d got=%h/%h exp=%h/%h", i, mon_addr[i],
                             mon_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
    endtask

    task automatic test_count_zero();
        clear_mon();
        tx_words.delete();
        send_packet(16'h0020, 16'd0, 0);
        idle(4);
        #1;
        checks++;
        if (mon_addr.size() != 0) begin
            failures++;
            $display("FAIL zero_writes got=%0d exp=0", mon_addr.size());
        end
        checks++;
        if (done_stamp.size() != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_done got=%0d/busy=%b exp=1/busy=0", done_stamp.size(), busy);
        end else begin
            checks++;
            if (done_stamp[0] != last_stamp + 1) begin
                failures++;
                $display("FAIL zero_timing got=%0d exp=%0d", done_stamp[0], last_stamp + 1);
            end
        end
    endtask

    task automatic test_timeout();
        logic [15:0] a;
        clear_mon();
        rand_words(2);
        a = 16'h0155;
        drive_byte(8'hA5);
        drive_byte(a[15:8]);
        drive_byte(a[7:0]);
        drive_byte(8'h00);
        drive_byte(8'h02);
        for (int j = 4; j >= 0; j--) drive_byte(tx_words[0][8*j +: 8]);
        drive_byte(tx_words[1][39:32]);
        drive_byte(tx_words[1][31:24]);
        idle(1);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_busy_mid got=%b exp=1", busy);
        end
        idle(TO + 8);
        #1;
        model_packet(a, 1);
        checks++;
        if (errt_stamp.size() != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse got=%0d/busy=%b exp=1/busy=0", errt_stamp.size(), busy);
        end else begin
            checks++;
            if (errt_stamp[0] != last_stamp + TO + 2) begin
                failures++;
                $display("FAIL timeout_timing got=%0d exp=%0d", errt_stamp[0], last_stamp + TO + 2);
            end
        end
        checks++;
        if (mon_addr.size() != 1 || done_stamp.size() != 0) begin
            failures++;
            $display("FAIL timeout_writes got=w%0d/d%0d exp=w1/d0", mon_addr.size(),
                     done_stamp.size());
        end else begin
            checks++;
            if (mon_addr[0] != exp_addr[0] || mon_data[0] !== exp_data[0]) begin
                failures++;
                $display("FAIL timeout_kept got=%h/%h exp=%h/%h", mon_addr[0], mon_data[0],
                         exp_addr[0], exp_data[0]);
            end
        end
        clear_mon();
        rand_words(1);
        send_packet(16'h0077, 16'd1, 1);
        idle(4);
        #1;
        model_packet(16'h0077, 1);
        checks++;
        if (mon_addr.size() != 1 || done_stamp.size() != 1) begin
            failures++;
            $display("FAIL timeout_follow got=w%0d/d%0d exp=w1/d1", mon_addr.size(),
                     done_stamp.size());
        end else if (mon_addr[0] != exp_addr[0] || mon_data[0] !== exp_data[0]) begin
            failures++;
            $display("FAIL timeout_follow_data got=%h/%h exp=%h/%h", mon_addr[0], mon_data[0],
                     exp_addr[0], exp_data[0]);
        end
    endtask

    task automatic test_mid_reset();
        clear_mon();
        drive_byte(8'hA5);
        drive_byte(8'h01);
        drive_byte(8'h23);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({param_wr_en, param_wr_addr, param_wr_data, busy, in_ready} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got=%b/%h/%h/%b/%b exp=all zero", param_wr_en,
                     param_wr_addr, param_wr_data, busy, in_ready);
        end
        reset = 1'b0;
        rand_words(1);
        send_packet(16'hFC40, 16'd1, 0);
        idle(4);
        #1;
        model_packet(16'hFC40, 1);
        checks++;
        if (done_stamp.size() != 1 || errc_stamp.size() != 0 || errt_stamp.size() != 0) begin
            failures++;
            $display("FAIL midreset_pulses got=d%0d/c%0d/t%0d exp=d1/c0/t0", done_stamp.size(),
                     errc_stamp.size(), errt_stamp.size());
        end
        checks++;
        if (mon_addr.size() != 1) begin
            failures++;
            $display("FAIL midreset_count got=%0d exp=1", mon_addr.size());
        end else if (mon_addr[0] != exp_addr[0] || mon_data[0] !== exp_data[0]) begin
            failures++;
            $display("FAIL midreset_write got=%h/%h exp=%h/%h", mon_addr[0], mon_data[0],
                     exp_addr[0], exp_data[0]);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [7:0]  b;
        int          n;
        bit          bad;
        int          bad_stamp;
        for (int p = 0; p < 10; p++) begin
            clear_mon();
            a   = 16'($urandom());
            n   = $urandom_range(0, 4);
            bad = ($urandom_range(0, 2) == 0);
            bad_stamp = 0;
            rand_words(n);
            if (bad) begin
                b = 8'($urandom());
                if (b == 8'hA5) b = 8'h00;
                drive_byte(b);
                bad_stamp = last_stamp;
                idle(1);
            end
            send_packet(a, 16'(n), 3);
            idle(4);
            #1;
            model_packet(a, n);
            checks++;
            if (mon_addr.size() != n) begin
                failures++;
                $display("FAIL rand%0d_count got=%0d exp=%0d", p, mon_addr.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (mon_addr[i] != exp_addr[i] || mon_data[i] !== exp_data[i]) begin
                        failures++;
                        $display("FAIL rand%0d_write%0d got=%h/%h exp=%h/%h", p, i, mon_addr[i],
                                 mon_data[i], exp_addr[i], exp_data[i]);
                    end
                end
            end
            checks++;
            if (done_stamp.size() != 1 || done_stamp[0] != last_stamp + 1) begin
                failures++;
                $display("FAIL rand%0d_done got=%0d@%0d exp=1@%0d", p, done_stamp.size(),
                         (done_stamp.size() > 0) ? done_stamp[0] : -1, last_stamp + 1);
            end
            checks++;
            if (errc_stamp.size() != int'(bad) || errt_stamp.size() != 0 ||
                (bad && errc_stamp.size() == 1 && errc_stamp[0] != bad_stamp + 1)) begin
                failures++;
                $display("FAIL rand%0d_errs got=c%0d/t%0d exp=c%0d/t0", p, errc_stamp.size(),
                         errt_stamp.size(), int'(bad));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_burst_wrap();
        test_bad_cmd();
        test_count_zero();
        test_timeout();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
